// File: rtl/doc_uart_pkg.sv
// Shared types and helpers for the document UART streamer.
// Optional build macro: DOC_UART_TRIM_TRAILING_EN (trailing-blank trim).
package doc_uart_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    FETCH,
    CHAR,
    EOL_CR,
    EOL_LF,
    NEXT_ROW,
    FINISH,
    SCAN_ADDR,
    SCAN_FETCH
  } state_t;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SPACE = 8'h20;

  function automatic logic [9:0] addr_pack(
    input logic [3:0] row,
    input logic [4:0] col
  );
    return {1'b0, row, col};
  endfunction

endpackage

// File: rtl/doc_uart_streamer_tx.sv
// UART 8N1 byte transmitter with valid/ready handshake.
// ready rises on the last stop-bit cycle so frames can run back to back.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [TW-1:0] timer;
  logic [3:0]    bitn;
  logic [8:0]    shreg;
  logic          last_tick;

  assign last_tick = (timer == TLAST);
  assign ready = !active || (bitn == 4'd9 && last_tick);

  // Load a frame on accept, then shift one bit per bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      timer  <= '0;
      bitn   <= '0;
      shreg  <= '1;
      tx     <= 1'b1;
    end else if (valid && ready) begin
      active <= 1'b1;
      timer  <= '0;
      bitn   <= '0;
      shreg  <= {1'b1, data};
      tx     <= 1'b0;
    end else if (active) begin
      if (last_tick) begin
        timer <= '0;
        if (bitn == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bitn  <= bitn + 4'd1;
          tx    <= shreg[0];
          shreg <= {1'b1, shreg[8:1]};
        end
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/doc_uart_streamer.sv
// Walks the text grid and streams it over UART with CR/LF per row.
// Optional build macro: DOC_UART_TRIM_TRAILING_EN (skip trailing blanks).
module doc_uart_streamer
  import doc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int ROWS         = 15,
  parameter int COLS         = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] read_data,
  output logic       read_en,
  output logic [9:0] read_addr,
  output logic       RsTx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic [4:0] COL_LAST = 5'(COLS - 1);

`ifdef DOC_UART_TRIM_TRAILING_EN
  localparam state_t ROW_START = SCAN_ADDR;
`else
  localparam state_t ROW_START = ADDR;
`endif

  state_t     state;
  logic [3:0] row;
  logic [4:0] col;
  logic [7:0] char_q;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       accept;
  logic       col_end;

`ifdef DOC_UART_TRIM_TRAILING_EN
  logic [4:0] last;
  logic       any;
  logic       nonblank;

  assign nonblank = (read_data != 8'h00) && (read_data != SPACE);
  assign col_end  = (col == last);
`else
  assign col_end  = (col == COL_LAST);
`endif

  assign accept = tx_valid && tx_ready;

  // Select which byte, if any, is offered to the transmitter.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = char_q;
    unique case (state)
      CHAR:    tx_valid = 1'b1;
      EOL_CR: begin
        tx_valid = 1'b1;
        tx_data  = CR;
      end
      EOL_LF: begin
        tx_valid = 1'b1;
        tx_data  = LF;
      end
      default: ;
    endcase
  end

  // Transfer sequencer with registered port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      char_q    <= SPACE;
      read_en   <= 1'b0;
      read_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DOC_UART_TRIM_TRAILING_EN
      last      <= '0;
      any       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (send) begin
            state     <= ROW_START;
            row       <= '0;
            col       <= '0;
            read_addr <= addr_pack(4'd0, 5'd0);
            read_en   <= 1'b1;
            busy      <= 1'b1;
`ifdef DOC_UART_TRIM_TRAILING_EN
            last      <= '0;
            any       <= 1'b0;
`endif
          end
        end
        ADDR: state <= FETCH;
        FETCH: begin
          char_q <= (read_data == 8'h00) ? SPACE : read_data;
          state  <= CHAR;
        end
        CHAR: begin
          if (accept) begin
            col <= col + 5'd1;
            if (col_end) begin
              state <= EOL_CR;
            end else begin
              state     <= ADDR;
              read_addr <= addr_pack(row, col + 5'd1);
            end
          end
        end
        EOL_CR: if (accept) state <= EOL_LF;
        EOL_LF: if (accept) state <= NEXT_ROW;
        NEXT_ROW: begin
          row <= row + 4'd1;
          col <= '0;
`ifdef DOC_UART_TRIM_TRAILING_EN
          last <= '0;
          any  <= 1'b0;
`endif
          if (row == ROW_LAST) begin
            state <= FINISH;
          end else begin
            state     <= ROW_START;
            read_addr <= addr_pack(row + 4'd1, 5'd0);
          end
        end
        FINISH: begin
          if (tx_ready) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            read_en <= 1'b0;
            state   <= IDLE;
          end
        end
`ifdef DOC_UART_TRIM_TRAILING_EN
        SCAN_ADDR: state <= SCAN_FETCH;
        SCAN_FETCH: begin
          if (nonblank) begin
            last <= col;
            any  <= 1'b1;
          end
          if (col == COL_LAST) begin
            col       <= '0;
            read_addr <= addr_pack(row, 5'd0);
            state     <= (any || nonblank) ? ADDR : EOL_CR;
          end else begin
            col       <= col + 5'd1;
            read_addr <= addr_pack(row, col + 5'd1);
            state     <= SCAN_ADDR;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .valid(tx_valid),
    .data (tx_data),
    .ready(tx_ready),
    .tx   (RsTx)
  );

endmodule
